// File: rtl/uart_mmio_responder.sv
// rtl/uart_mmio_responder.sv - memory-mapped UART responder with TX/RX byte FIFOs
// Registers at 0x0 TXDATA, 0x4 RXDATA, 0x8 STATUS, 0xC CTRL; loads return one cycle later.
module uart_mmio_responder #(
  parameter int TX_DEPTH_LOG2 = 4,
  parameter int RX_DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [3:0]  addr_ofs,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        available_o,
  output logic        tx_valid,
  output logic [7:0]  tx_byte,
  input  logic        tx_ready,
  input  logic        rx_ready,
  input  logic [7:0]  rx_byte,
  output logic        rx_pop,
  output logic        irq
);

  localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;
  localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;
  localparam int TX_CW    = TX_DEPTH_LOG2 + 1;
  localparam int RX_CW    = RX_DEPTH_LOG2 + 1;

  typedef enum logic {RX_IDLE, RX_GUARD} rx_state_t;

  logic [7:0]               tx_mem [TX_DEPTH];
  logic [7:0]               rx_mem [RX_DEPTH];
  logic [TX_DEPTH_LOG2-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [RX_DEPTH_LOG2-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [TX_CW-1:0]         tx_count;
  logic [RX_CW-1:0]         rx_count;
  logic                     tx_ovf, rx_unf, rx_irq_en;
  rx_state_t                rx_state;
  logic [31:0]              rd_next;
  logic                     unused_wr_bits;

  logic wr_q, rd_q, ctrl_wr, tx_flush, rx_flush, clr_sticky;
  logic tx_full, tx_push_req, tx_do_push, tx_do_pop, tx_ovf_set;
  logic rx_full, rx_empty, rx_rd, rx_do_pop, rx_do_push, rx_unf_set;

  assign wr_q        = sel & wr_en;
  assign rd_q        = sel & rd_en;
  assign ctrl_wr     = wr_q && (addr_ofs == 4'hC);
  assign tx_flush    = ctrl_wr & wr_data[0];
  assign rx_flush    = ctrl_wr & wr_data[1];
  assign clr_sticky  = ctrl_wr & wr_data[2];
  assign unused_wr_bits = ^wr_data[31:8];

  assign tx_full     = (tx_count == TX_CW'(TX_DEPTH));
  assign tx_push_req = wr_q && (addr_ofs == 4'h0);
  assign tx_do_push  = tx_push_req & ~tx_full & ~tx_flush;
  assign tx_ovf_set  = tx_push_req & tx_full & ~tx_flush;
  assign tx_valid    = (tx_count != '0);
  assign tx_byte     = tx_mem[tx_rd_ptr];
  assign tx_do_pop   = tx_valid & tx_ready;

  assign rx_full     = (rx_count == RX_CW'(RX_DEPTH));
  assign rx_empty    = (rx_count == '0);
  assign rx_rd       = rd_q && (addr_ofs == 4'h4);
  assign rx_do_pop   = rx_rd & ~rx_empty;
  assign rx_unf_set  = rx_rd & rx_empty;
  // Push decision uses pre-edge fullness, so a same-cycle CPU pop does not open a slot early.
  assign rx_do_push  = (rx_state == RX_IDLE) & rx_ready & ~rx_full & ~rx_flush;

  assign available_o = 1'b1;
  assign irq         = rx_irq_en & ~rx_empty;

  always_ff @(posedge clk) begin
    if (tx_do_push) tx_mem[tx_wr_ptr] <= wr_data[7:0];
    if (rx_do_push) rx_mem[rx_wr_ptr] <= rx_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else if (tx_flush) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_do_push) tx_wr_ptr <= tx_wr_ptr + TX_DEPTH_LOG2'(1);
      if (tx_do_pop)  tx_rd_ptr <= tx_rd_ptr + TX_DEPTH_LOG2'(1);
      case ({tx_do_push, tx_do_pop})
        2'b10:   tx_count <= tx_count + TX_CW'(1);
        2'b01:   tx_count <= tx_count - TX_CW'(1);
        default: tx_count <= tx_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else if (rx_flush) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_do_push) rx_wr_ptr <= rx_wr_ptr + RX_DEPTH_LOG2'(1);
      if (rx_do_pop)  rx_rd_ptr <= rx_rd_ptr + RX_DEPTH_LOG2'(1);
      case ({rx_do_push, rx_do_pop})
        2'b10:   rx_count <= rx_count + RX_CW'(1);
        2'b01:   rx_count <= rx_count - RX_CW'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

  // GUARD gives uart_rx one cycle to drop rx_ready after the acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_pop   <= 1'b0;
    end else if (rx_flush) begin
      rx_state <= RX_IDLE;
      rx_pop   <= 1'b0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          rx_pop <= rx_do_push;
          if (rx_do_push) rx_state <= RX_GUARD;
        end
        default: begin
          rx_pop   <= 1'b0;
          rx_state <= RX_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    rd_next = 32'h0;
    case (addr_ofs)
      4'h4: rd_next = rx_empty ? 32'h0 : {24'h0, rx_mem[rx_rd_ptr]};
      4'h8: rd_next = {8'h0, 8'(rx_count), 8'(tx_count), 3'b0, rx_unf, tx_ovf,
                       ~tx_valid, ~rx_empty, ~tx_full};
      4'hC: rd_next = {28'h0, rx_irq_en, 3'b0};
      default: rd_next = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data   <= 32'h0;
      tx_ovf    <= 1'b0;
      rx_unf    <= 1'b0;
      rx_irq_en <= 1'b0;
    end else begin
      if (rd_q) rd_data <= rd_next;
      if (ctrl_wr) rx_irq_en <= wr_data[3];
      tx_ovf <= (tx_ovf & ~clr_sticky) | tx_ovf_set;
      rx_unf <= (rx_unf & ~clr_sticky) | rx_unf_set;
    end
  end

endmodule

// File: tb/tb_uart_mmio_responder.sv
// tb/tb_uart_mmio_responder.sv - directed table and sequence bench for uart_mmio_responder
module tb_uart_mmio_responder;

  logic        clk = 1'b0;
  logic        rst_n, sel, wr_en, rd_en, tx_ready, rx_ready;
  logic [3:0]  addr_ofs;
  logic [31:0] wr_data, rd_data;
  logic [7:0]  rx_byte, tx_byte;
  logic        available_o, tx_valid, rx_pop, irq;

  int total = 0;
  int passed = 0;
  int pops;

  uart_mmio_responder #(.TX_DEPTH_LOG2(4), .RX_DEPTH_LOG2(4)) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .wr_en(wr_en), .rd_en(rd_en),
    .addr_ofs(addr_ofs), .wr_data(wr_data), .rd_data(rd_data),
    .available_o(available_o), .tx_valid(tx_valid), .tx_byte(tx_byte),
    .tx_ready(tx_ready), .rx_ready(rx_ready), .rx_byte(rx_byte),
    .rx_pop(rx_pop), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic        r;
    logic [3:0]  a;
    logic [31:0] d;
    logic        chk;
    logic [31:0] exp_rd;
    logic        exp_txv;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Called just after a falling edge; returns at the next falling edge.
  task automatic bus(input logic w, input logic r, input logic [3:0] a, input logic [31:0] d);
    sel = 1'b1; wr_en = w; rd_en = r; addr_ofs = a; wr_data = d;
    @(negedge clk);
    sel = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr_ofs = 4'h0;
    wr_data = 32'h0; tx_ready = 1'b0; rx_ready = 1'b0; rx_byte = 8'h0;

    vecs[0] = '{1'b0, 1'b1, 4'h8, 32'h0, 1'b1, 32'h0000_0005, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 4'h0, 32'h41, 1'b0, 32'h0, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 4'h0, 32'h42, 1'b0, 32'h0, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 4'h8, 32'h0, 1'b1, 32'h0000_0201, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 4'hC, 32'h0, 1'b1, 32'h0000_0000, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 4'hC, 32'h8, 1'b0, 32'h0, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 4'hC, 32'h0, 1'b1, 32'h0000_0008, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 4'h3, 32'h0, 1'b1, 32'h0000_0000, 1'b1};
    vecs[8] = '{1'b1, 1'b0, 4'hC, 32'h1, 1'b0, 32'h0, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 4'h8, 32'h0, 1'b1, 32'h0000_0005, 1'b0};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("reset rd_data", rd_data, 32'h0);
    check("reset available_o", {31'h0, available_o}, 32'h1);
    check("reset tx_valid", {31'h0, tx_valid}, 32'h0);
    check("reset rx_pop", {31'h0, rx_pop}, 32'h0);
    check("reset irq", {31'h0, irq}, 32'h0);

    for (int i = 0; i < 10; i++) begin
      bus(vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].d);
      if (vecs[i].chk) check($sformatf("vec%0d rd_data", i), rd_data, vecs[i].exp_rd);
      check($sformatf("vec%0d tx_valid", i), {31'h0, tx_valid}, {31'h0, vecs[i].exp_txv});
    end

    // TX drain in order
    bus(1, 0, 4'h0, 32'h41);
    bus(1, 0, 4'h0, 32'h42);
    check("drain head0", {24'h0, tx_byte}, 32'h41);
    tx_ready = 1'b1;
    step();
    check("drain head1", {24'h0, tx_byte}, 32'h42);
    check("drain valid1", {31'h0, tx_valid}, 32'h1);
    step();
    check("drain empty", {31'h0, tx_valid}, 32'h0);
    tx_ready = 1'b0;

    // Same-cycle push and drain pop keep the count
    bus(1, 0, 4'h0, 32'h77);
    tx_ready = 1'b1;
    bus(1, 0, 4'h0, 32'h78);
    tx_ready = 1'b0;
    check("pushpop head", {24'h0, tx_byte}, 32'h78);
    bus(0, 1, 4'h8, 32'h0);
    check("pushpop status", rd_data, 32'h0000_0101);
    bus(1, 0, 4'hC, 32'h1);

    // Overflow, clear_sticky, flush
    for (int i = 0; i < 17; i++) bus(1, 0, 4'h0, 32'h10 + i);
    bus(0, 1, 4'h8, 32'h0);
    check("ovf status", rd_data, 32'h0000_1008);
    check("ovf head", {24'h0, tx_byte}, 32'h10);
    bus(1, 0, 4'hC, 32'h4);
    bus(0, 1, 4'h8, 32'h0);
    check("clr sticky status", rd_data, 32'h0000_1000);
    bus(1, 0, 4'hC, 32'h1);
    bus(0, 1, 4'h8, 32'h0);
    check("tx flush status", rd_data, 32'h0000_0005);

    // RX fill with a stale rx_ready during the guard cycle
    rx_byte = 8'h55; rx_ready = 1'b1;
    step();
    check("rx pop 55", {31'h0, rx_pop}, 32'h1);
    step();
    check("rx guard", {31'h0, rx_pop}, 32'h0);
    rx_byte = 8'hAA;
    step();
    check("rx pop AA", {31'h0, rx_pop}, 32'h1);
    rx_ready = 1'b0;
    step();
    bus(0, 1, 4'h8, 32'h0);
    check("rx2 status", rd_data, 32'h0002_0007);
    check("irq disabled", {31'h0, irq}, 32'h0);
    bus(1, 0, 4'hC, 32'h8);
    check("irq enabled", {31'h0, irq}, 32'h1);
    bus(0, 1, 4'h4, 32'h0);
    check("rx read 55", rd_data, 32'h55);
    bus(0, 1, 4'h4, 32'h0);
    check("rx read AA", rd_data, 32'hAA);
    check("irq after drain", {31'h0, irq}, 32'h0);

    // Underflow, then same-cycle CTRL read+write with clear_sticky
    bus(0, 1, 4'h4, 32'h0);
    check("rx unf data", rd_data, 32'h0);
    bus(0, 1, 4'h8, 32'h0);
    check("rx unf status", rd_data, 32'h0000_0015);
    bus(1, 1, 4'hC, 32'hC);
    check("ctrl rw pre-edge", rd_data, 32'h0000_0008);
    bus(0, 1, 4'h8, 32'h0);
    check("unf cleared", rd_data, 32'h0000_0005);

    // RX full back-pressure
    bus(1, 0, 4'h0, 32'h33);
    pops = 0;
    for (int i = 0; i < 16; i++) begin
      rx_byte = 8'(8'h10 + i); rx_ready = 1'b1;
      step(); pops += int'(rx_pop);
      step(); pops += int'(rx_pop);
    end
    check("fill pops", pops, 16);
    rx_byte = 8'h99;
    pops = 0;
    repeat (3) begin
      step(); pops += int'(rx_pop);
    end
    check("full no pop", pops, 0);
    check("full irq", {31'h0, irq}, 32'h1);
    bus(0, 1, 4'h8, 32'h0);
    check("full status", rd_data, 32'h0010_0103);
    bus(0, 1, 4'h4, 32'h0);
    check("full pop data", rd_data, 32'h10);
    check("no pop same edge", {31'h0, rx_pop}, 32'h0);
    step();
    check("refill pop", {31'h0, rx_pop}, 32'h1);
    check("pre-reset tx_valid", {31'h0, tx_valid}, 32'h1);

    // Asynchronous reset mid-transfer
    #2 rst_n = 1'b0;
    #1;
    check("async rd_data", rd_data, 32'h0);
    check("async tx_valid", {31'h0, tx_valid}, 32'h0);
    check("async rx_pop", {31'h0, rx_pop}, 32'h0);
    check("async irq", {31'h0, irq}, 32'h0);
    check("async available", {31'h0, available_o}, 32'h1);
    rx_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus(0, 1, 4'h8, 32'h0);
    check("post reset status", rd_data, 32'h0000_0005);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
